// File: rtl/pipelined_adder_pkg.sv
// Shared defaults and helpers for the sliced, pipelined add/subtract datapath.
package pipelined_adder_pkg;

  localparam int unsigned PA_WIDTH_DEFAULT = 32;
  localparam int unsigned PA_CHUNK_DEFAULT = 8;

  function automatic int unsigned pa_stages(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/pipelined_adder_slice.sv
// Purely combinational CHUNK-bit adder with carry in/out; one per pipeline stage.
module adder_slice #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract split into carry-linked CHUNK slices, one register stage
// per slice, streaming through a valid/ready chain with full backpressure.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned WIDTH = PA_WIDTH_DEFAULT,
  parameter int unsigned CHUNK = PA_CHUNK_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned STAGES = pa_stages(WIDTH, CHUNK);

  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_carry;
  logic [WIDTH-1:0]  r_a   [STAGES];
  logic [WIDTH-1:0]  r_b   [STAGES];
  logic [WIDTH-1:0]  r_sum [STAGES];
  logic              r_loaded;

  logic [STAGES-1:0] w_ready;
  logic [STAGES-1:0] w_load;
  logic [WIDTH-1:0]  w_b_eff;
  logic              w_c0;
  logic [CHUNK-1:0]  w_sl_a   [STAGES];
  logic [CHUNK-1:0]  w_sl_b   [STAGES];
  logic [CHUNK-1:0]  w_sl_sum [STAGES];
  logic [STAGES-1:0] w_sl_cin;
  logic [STAGES-1:0] w_sl_cout;

  assign w_b_eff = sub ? ~operand2 : operand2;
  assign w_c0    = carry_in ^ sub;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Stage k can move iff out_ready or some stage at or beyond k is empty.
    localparam logic [STAGES-1:0] LOW_MASK = {STAGES{1'b1}} >> (STAGES - k);
    assign w_ready[k] = out_ready | ~&(r_valid | LOW_MASK);

    if (k == 0) begin : g_first
      assign w_sl_a[k]   = operand1[CHUNK-1:0];
      assign w_sl_b[k]   = w_b_eff[CHUNK-1:0];
      assign w_sl_cin[k] = w_c0;
      assign w_load[k]   = w_ready[k] & in_valid;
    end else begin : g_next
      assign w_sl_a[k]   = r_a[k-1][k*CHUNK +: CHUNK];
      assign w_sl_b[k]   = r_b[k-1][k*CHUNK +: CHUNK];
      assign w_sl_cin[k] = r_carry[k-1];
      assign w_load[k]   = w_ready[k] & r_valid[k-1];
    end

    adder_slice #(.CHUNK(CHUNK)) u_slice (
      .i_a    (w_sl_a[k]),
      .i_b    (w_sl_b[k]),
      .i_cin  (w_sl_cin[k]),
      .o_sum  (w_sl_sum[k]),
      .o_cout (w_sl_cout[k])
    );
  end

  // Data registers only load with a real operation so outputs hold across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= '0;
      r_carry  <= '0;
      r_loaded <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
      end
    end else begin
      if (w_ready[0]) r_valid[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        if (w_ready[k]) r_valid[k] <= r_valid[k-1];
      end
      if (w_load[0]) begin
        r_a[0]     <= operand1;
        r_b[0]     <= w_b_eff;
        r_sum[0]   <= WIDTH'(w_sl_sum[0]);
        r_carry[0] <= w_sl_cout[0];
      end
      for (int k = 1; k < STAGES; k++) begin
        if (w_load[k]) begin
          r_a[k]   <= r_a[k-1];
          r_b[k]   <= r_b[k-1];
          r_sum[k] <= r_sum[k-1];
          r_sum[k][k*CHUNK +: CHUNK] <= w_sl_sum[k];
          r_carry[k] <= w_sl_cout[k];
        end
      end
      if (w_load[STAGES-1]) r_loaded <= 1'b1;
    end
  end

  assign in_ready  = w_ready[0];
  assign out_valid = r_valid[STAGES-1];
  assign result    = r_sum[STAGES-1];
  assign carry_out = r_carry[STAGES-1];
  assign overflow  = (r_a[STAGES-1][WIDTH-1] == r_b[STAGES-1][WIDTH-1]) &&
                     (r_sum[STAGES-1][WIDTH-1] != r_a[STAGES-1][WIDTH-1]);
  // zero stays low until the first real result reaches the output stage.
  assign zero      = r_loaded && (r_sum[STAGES-1] == '0);

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed 32/8 cases plus random sweeps of 16/16 and 64/8
// against an arithmetic scoreboard.
module tb_pipelined_adder;

  typedef struct packed {
    logic [63:0] res;
    logic        co;
    logic        ov;
    logic        zr;
    logic [31:0] acc;
  } exp_t;

  int W_OF [3] = '{32, 16, 64};
  int S_OF [3] = '{4, 1, 8};

  logic        clk;
  logic        rst_n;
  logic [2:0]  iv;
  logic [2:0]  ordy;
  logic [63:0] opa  [3];
  logic [63:0] opb  [3];
  logic [2:0]  cin;
  logic [2:0]  subv;
  logic [2:0]  strict;

  wire  [2:0]  irdy;
  wire  [2:0]  ovld;
  wire  [2:0]  cov;
  wire  [2:0]  vov;
  wire  [2:0]  zr;
  wire  [31:0] res0;
  wire  [15:0] res1;
  wire  [63:0] res2;
  wire  [63:0] res_w [3];

  assign res_w[0] = {32'd0, res0};
  assign res_w[1] = {48'd0, res1};
  assign res_w[2] = res2;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  exp_t exp_mem [3][4096];
  int   wr [3] = '{0, 0, 0};
  int   rd [3] = '{0, 0, 0};
  int   nx [3] = '{0, 0, 0};
  bit   seen [3] = '{0, 0, 0};

  pipelined_adder #(.WIDTH(32), .CHUNK(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]),
    .operand1(opa[0][31:0]), .operand2(opb[0][31:0]), .carry_in(cin[0]), .sub(subv[0]),
    .out_valid(ovld[0]), .out_ready(ordy[0]), .result(res0),
    .carry_out(cov[0]), .overflow(vov[0]), .zero(zr[0]));

  pipelined_adder #(.WIDTH(16), .CHUNK(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]),
    .operand1(opa[1][15:0]), .operand2(opb[1][15:0]), .carry_in(cin[1]), .sub(subv[1]),
    .out_valid(ovld[1]), .out_ready(ordy[1]), .result(res1),
    .carry_out(cov[1]), .overflow(vov[1]), .zero(zr[1]));

  pipelined_adder #(.WIDTH(64), .CHUNK(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]),
    .operand1(opa[2]), .operand2(opb[2]), .carry_in(cin[2]), .sub(subv[2]),
    .out_valid(ovld[2]), .out_ready(ordy[2]), .result(res2),
    .carry_out(cov[2]), .overflow(vov[2]), .zero(zr[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: plain modular arithmetic on the masked operands.
  function automatic exp_t ref_add(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic ci, input logic s, input int acc);
    exp_t        e;
    logic [64:0] full;
    logic [63:0] mask, am, bm;
    mask  = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    am    = a & mask;
    bm    = (s ? ~b : b) & mask;
    full  = {1'b0, am} + {1'b0, bm} + 65'(ci ^ s);
    e.res = full[63:0] & mask;
    e.co  = full[w];
    e.ov  = (am[w-1] == bm[w-1]) && (e.res[w-1] != am[w-1]);
    e.zr  = (e.res == 64'd0);
    e.acc = acc;
    return e;
  endfunction

  always @(negedge clk) begin : p_mon
    exp_t e;
    int   lat;
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        rd[d]   = wr[d];
        seen[d] = 1'b0;
      end else begin
        check($sformatf("d%0d_in_ready", d), 64'(irdy[d]),
              64'(!(((wr[d] - rd[d]) == S_OF[d]) && !ordy[d])));
        if (ovld[d]) begin
          if (wr[d] == rd[d]) begin
            check($sformatf("d%0d_spurious_valid", d), 64'(ovld[d]), 64'd0);
          end else begin
            e = exp_mem[d][rd[d] % 4096];
            check($sformatf("d%0d_result", d), res_w[d], e.res);
            check($sformatf("d%0d_carry", d), 64'(cov[d]), 64'(e.co));
            check($sformatf("d%0d_overflow", d), 64'(vov[d]), 64'(e.ov));
            check($sformatf("d%0d_zero", d), 64'(zr[d]), 64'(e.zr));
            if (!seen[d]) begin
              seen[d] = 1'b1;
              lat = cyc - int'(e.acc);
              if (strict[d]) check($sformatf("d%0d_latency", d), 64'(lat), 64'(S_OF[d]));
              else           check($sformatf("d%0d_latency_min", d), 64'(lat >= S_OF[d]), 64'd1);
            end
            if (ordy[d]) begin
              rd[d]++;
              nx[d]++;
              seen[d] = 1'b0;
            end
          end
        end
        if (iv[d] && irdy[d]) begin
          exp_mem[d][wr[d] % 4096] = ref_add(W_OF[d], opa[d], opb[d], cin[d], subv[d], cyc);
          wr[d]++;
        end
      end
    end
  end

  task automatic send0(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic s);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    opa[0] = {32'd0, a}; opb[0] = {32'd0, b}; cin[0] = ci; subv[0] = s; iv[0] = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (irdy[0]) begin got = 1'b1; break; end
    end
    if (!got) check("send0_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    iv[0] = 1'b0;
  endtask

  task automatic chk_out0(input string tag, input logic [31:0] r, input logic c,
                          input logic v, input logic z);
    for (int t = 0; t < 40; t++) begin
      if (ovld[0]) break;
      @(negedge clk);
    end
    check({tag, "_valid"}, 64'(ovld[0]), 64'd1);
    check({tag, "_result"}, res_w[0], {32'd0, r});
    check({tag, "_carry"}, 64'(cov[0]), 64'(c));
    check({tag, "_overflow"}, 64'(vov[0]), 64'(v));
    check({tag, "_zero"}, 64'(zr[0]), 64'(z));
  endtask

  task automatic run_sweep(input int n, input bit strict_mode);
    int sent [3];
    bit pend [3];
    bit acc  [3];
    sent = '{0, 0, 0};
    pend = '{0, 0, 0};
    acc  = '{0, 0, 0};
    strict[1] = strict_mode;
    strict[2] = strict_mode;
    for (int t = 0; t < 20000; t++) begin
      @(posedge clk); #1;
      for (int d = 1; d < 3; d++) begin
        if (acc[d]) begin sent[d]++; pend[d] = 1'b0; end
        if (!pend[d] && sent[d] < n && $urandom_range(3) != 0) begin
          opa[d]  = {$urandom, $urandom};
          opb[d]  = {$urandom, $urandom};
          cin[d]  = 1'($urandom_range(1));
          subv[d] = 1'($urandom_range(1));
          pend[d] = 1'b1;
        end
        iv[d]   = pend[d];
        ordy[d] = strict_mode ? 1'b1 : ($urandom_range(2) != 0);
      end
      @(negedge clk);
      for (int d = 1; d < 3; d++) acc[d] = iv[d] & irdy[d];
      if (sent[1] == n && sent[2] == n && wr[1] == rd[1] && wr[2] == rd[2]) break;
    end
    iv[1] = 1'b0; iv[2] = 1'b0; ordy[1] = 1'b1; ordy[2] = 1'b1;
    check("sweep_sent_d1", 64'(sent[1]), 64'(n));
    check("sweep_sent_d2", 64'(sent[2]), 64'(n));
    check("sweep_drained_d1", 64'(wr[1] - rd[1]), 64'd0);
    check("sweep_drained_d2", 64'(wr[2] - rd[2]), 64'd0);
  endtask

  initial begin : p_watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : p_main
    int sent5;
    bit acc5;
    int nx_start;
    int pat [6];
    pat = '{1, 0, 0, 1, 0, 1};
    rst_n = 1'b0; iv = '0; ordy = '0; cin = '0; subv = '0; strict = '0;
    for (int d = 0; d < 3; d++) begin opa[d] = '0; opb[d] = '0; end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_d%0d_out_valid", d), 64'(ovld[d]), 64'd0);
      check($sformatf("rst_d%0d_result", d), res_w[d], 64'd0);
      check($sformatf("rst_d%0d_carry", d), 64'(cov[d]), 64'd0);
      check($sformatf("rst_d%0d_overflow", d), 64'(vov[d]), 64'd0);
      check($sformatf("rst_d%0d_zero", d), 64'(zr[d]), 64'd0);
    end
    @(posedge clk); #2 rst_n = 1'b1;

    // Fill the 4-stage pipe with out_ready low, then reset mid-cycle
    for (int i = 0; i < 4; i++) send0($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
    @(negedge clk);
    check("full_in_ready", 64'(irdy[0]), 64'd0);
    check("full_out_valid", 64'(ovld[0]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(ovld[0]), 64'd0);
    check("midrst_result", res_w[0], 64'd0);
    check("midrst_in_ready", 64'(irdy[0]), 64'd1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    ordy = 3'b111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst_no_stale", 64'(ovld[0]), 64'd0);
    end

    // Latency and directed arithmetic on the 32/8 instance
    strict[0] = 1'b1;
    send0(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lat_before", 64'(ovld[0]), 64'd0);
    end
    @(negedge clk);
    check("lat_exact", 64'(ovld[0]), 64'd1);
    chk_out0("t2_add", 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    send0(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    chk_out0("t3_ripple", 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    send0(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    chk_out0("t4_sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    send0(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
    chk_out0("t4_sub_borrow", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    strict[0] = 1'b0;

    // Backpressure: 10 back-to-back ops against a fixed out_ready pattern
    sent5 = 0; acc5 = 1'b0; nx_start = nx[0];
    for (int t = 0; t < 300; t++) begin
      @(posedge clk); #1;
      if (acc5) sent5++;
      if (acc5 || !iv[0]) begin
        opa[0] = {32'd0, $urandom}; opb[0] = {32'd0, $urandom};
        cin[0] = 1'($urandom_range(1)); subv[0] = 1'($urandom_range(1));
      end
      iv[0]   = (sent5 < 10);
      ordy[0] = (pat[t % 6] != 0);
      @(negedge clk);
      acc5 = iv[0] & irdy[0];
      if (nx[0] - nx_start == 10) break;
    end
    iv[0] = 1'b0; ordy[0] = 1'b1;
    check("bp_results", 64'(nx[0] - nx_start), 64'd10);
    check("bp_sent", 64'(sent5), 64'd10);

    // Parameter sweep: random traffic, then unstalled traffic with exact latency
    run_sweep(1000, 1'b0);
    run_sweep(50, 1'b1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
